gelato_operand_arbiter: RTL and testbench



---
 rtl/gelato_operand_arbiter_pkg.sv | 32 +++
 rtl/gelato_rr_arbiter.sv | 39 +++
 rtl/gelato_operand_arbiter.sv | 274 +++++++++++++++++++++++++++
 tb/tb_gelato_operand_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gelato_operand_arbiter_pkg.sv
// Shared types and helpers for the gelato operand arbiter.
// The typedefs describe the default configuration; the arbiter itself sizes its
// storage from its own parameters.
package gelato_types;

    localparam int DEF_BANK_NUM      = 4;
    localparam int DEF_COLLECTOR_NUM = 4;
    localparam int DEF_OPERAND_NUM   = 4;
    localparam int DEF_THREAD_NUM    = 32;

    typedef logic [$clog2(DEF_BANK_NUM)-1:0]      bank_idx_t;
    typedef logic [$clog2(DEF_COLLECTOR_NUM)-1:0] collector_idx_t;
    typedef logic [$clog2(DEF_OPERAND_NUM)-1:0]   operand_idx_t;
    typedef logic [DEF_THREAD_NUM*32-1:0]         warp_word_t;

    // Collector slot life cycle.
    typedef enum logic [0:0] {
        SLOT_IDLE = 1'b0,
        SLOT_BUSY = 1'b1
    } slot_state_t;

    // Warp-swizzled bank hash: (reg + warp) mod bank_num, bank_num a power of two.
    // Callers truncate the result to their bank index width.
    function automatic logic [31:0] bank_of(input logic [31:0] warp,
                                            input logic [31:0] rg,
                                            input int unsigned bank_num);
        logic [31:0] sum_s;
        sum_s = warp + rg;
        return sum_s & (bank_num - 32'd1);
    endfunction

endpackage

// File: rtl/gelato_rr_arbiter.sv
// N-way round-robin pick: scans requesters starting at ptr and returns the
// first active one. Purely combinational; the owner keeps the pointer.
module gelato_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx
);

    logic [IW:0]   sum_s;
    logic [IW-1:0] idx_s;

    // Rotating priority scan starting at the pointer, wrapping at N.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        sum_s       = '0;
        idx_s       = '0;
        for (int i = 0; i < N; i++) begin
            sum_s = {1'b0, ptr} + (IW+1)'(i);
            if (sum_s >= (IW+1)'(N)) begin
                sum_s = sum_s - (IW+1)'(N);
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[IW-1:0];
            if (!grant_valid && req[idx_s]) begin
                grant_valid = 1'b1;
                grant_idx   = idx_s;
            end else begin
                grant_valid = grant_valid;
            end
        end
    end

endmodule

// File: rtl/gelato_operand_arbiter.sv
// Register-file operand arbiter: collects multi-operand read requests from the
// collector slots, hashes each operand to a bank, grants one read per bank per
// cycle round-robin across slots, and routes read data back with its tags.
// A writeback to a bank pre-empts that bank's read for the cycle.
module gelato_operand_arbiter
    import gelato_types::*;
#(
    parameter int BANK_NUM      = 4,
    parameter int COLLECTOR_NUM = 4,
    parameter int OPERAND_NUM   = 4,
    parameter int WARP_NUM      = 32,
    parameter int REG_NUM       = 64,
    parameter int THREAD_NUM    = 32,
    localparam int WARP_W = $clog2(WARP_NUM),
    localparam int REG_W  = $clog2(REG_NUM),
    localparam int WORD_W = THREAD_NUM * 32,
    localparam int BANK_W = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1,
    localparam int CID_W  = (COLLECTOR_NUM > 1) ? $clog2(COLLECTOR_NUM) : 1,
    localparam int OID_W  = (OPERAND_NUM > 1) ? $clog2(OPERAND_NUM) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [COLLECTOR_NUM-1:0]               req_valid,
    output logic [COLLECTOR_NUM-1:0]               req_ready,
    input  logic [COLLECTOR_NUM*WARP_W-1:0]        req_warp,
    input  logic [COLLECTOR_NUM*OPERAND_NUM*REG_W-1:0] req_reg,
    input  logic [COLLECTOR_NUM*OPERAND_NUM-1:0]   req_mask,
    input  logic                                   wb_valid,
    input  logic [WARP_W-1:0]                      wb_warp,
    input  logic [REG_W-1:0]                       wb_reg,
    input  logic [THREAD_NUM-1:0]                  wb_mask,
    input  logic [WORD_W-1:0]                      wb_data,
    output logic [BANK_NUM-1:0]                    bank_rd_en,
    output logic [BANK_NUM*WARP_W-1:0]             bank_rd_warp,
    output logic [BANK_NUM*REG_W-1:0]              bank_rd_reg,
    input  logic [BANK_NUM*WORD_W-1:0]             bank_rd_data,
    output logic [BANK_NUM-1:0]                    bank_wr_en,
    output logic [WARP_W-1:0]                      bank_wr_warp,
    output logic [REG_W-1:0]                       bank_wr_reg,
    output logic [THREAD_NUM-1:0]                  bank_wr_mask,
    output logic [WORD_W-1:0]                      bank_wr_data,
    output logic [BANK_NUM-1:0]                    resp_valid,
    output logic [BANK_NUM*CID_W-1:0]              resp_collector,
    output logic [BANK_NUM*OID_W-1:0]              resp_operand,
    output logic [BANK_NUM*WORD_W-1:0]             resp_data,
    output logic [COLLECTOR_NUM-1:0]               slot_done
);

    // Per-slot request state.
    slot_state_t              state_r    [COLLECTOR_NUM];
    slot_state_t              state_nx_s [COLLECTOR_NUM];
    logic [WARP_W-1:0]        warp_r     [COLLECTOR_NUM];
    logic [REG_W-1:0]         reg_r      [COLLECTOR_NUM][OPERAND_NUM];
    logic [OPERAND_NUM-1:0]   pending_r  [COLLECTOR_NUM];
    logic [OPERAND_NUM-1:0]   clear_s    [COLLECTOR_NUM];
    logic [COLLECTOR_NUM-1:0] req_ready_r;
    logic [COLLECTOR_NUM-1:0] slot_done_r;
    logic [COLLECTOR_NUM-1:0] accept_s;
    logic [COLLECTOR_NUM-1:0] last_s;

    // Per-bank arbitration and response state.
    logic [CID_W-1:0]              rr_ptr_r [BANK_NUM];
    logic [BANK_NUM-1:0]           resp_valid_r;
    logic [BANK_NUM*CID_W-1:0]     resp_coll_r;
    logic [BANK_NUM*OID_W-1:0]     resp_op_r;

    logic [BANK_W-1:0]             op_bank_s [COLLECTOR_NUM][OPERAND_NUM];
    logic [BANK_W-1:0]             wb_bank_s;
    logic [31:0]                   hash_s;
    logic [BANK_NUM*COLLECTOR_NUM-1:0] cand_s;
    logic [BANK_NUM-1:0]           grant_valid_s;
    logic [BANK_NUM*CID_W-1:0]     grant_coll_s;
    logic [BANK_NUM-1:0]           rd_en_s;
    logic [BANK_NUM-1:0]           wr_en_s;
    logic [BANK_NUM*CID_W-1:0]     rd_coll_s;
    logic [BANK_NUM*OID_W-1:0]     rd_op_s;
    logic [CID_W-1:0]              gcoll_s;
    logic [OID_W-1:0]              gop_s;
    logic                          found_s;
    logic                          hit_s;

    // Bank hash of every latched operand and of the writeback, plus per-bank candidate slots.
    always_comb begin
        hash_s    = '0;
        wb_bank_s = '0;
        cand_s    = '0;
        for (int c = 0; c < COLLECTOR_NUM; c++) begin
            for (int o = 0; o < OPERAND_NUM; o++) begin
                hash_s          = bank_of(32'(warp_r[c]), 32'(reg_r[c][o]), BANK_NUM);
                op_bank_s[c][o] = hash_s[BANK_W-1:0];
            end
        end
        hash_s    = bank_of(32'(wb_warp), 32'(wb_reg), BANK_NUM);
        wb_bank_s = hash_s[BANK_W-1:0];
        for (int b = 0; b < BANK_NUM; b++) begin
            for (int c = 0; c < COLLECTOR_NUM; c++) begin
                for (int o = 0; o < OPERAND_NUM; o++) begin
                    cand_s[b*COLLECTOR_NUM+c] = cand_s[b*COLLECTOR_NUM+c] |
                        ((state_r[c] == SLOT_BUSY) && pending_r[c][o] &&
                         (op_bank_s[c][o] == BANK_W'(b)));
                end
            end
        end
    end

    for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
        gelato_rr_arbiter #(
            .N  (COLLECTOR_NUM),
            .IW (CID_W)
        ) u_arb (
            .req         (cand_s[b*COLLECTOR_NUM +: COLLECTOR_NUM]),
            .ptr         (rr_ptr_r[b]),
            .grant_valid (grant_valid_s[b]),
            .grant_idx   (grant_coll_s[b*CID_W +: CID_W])
        );
    end

    // Per-bank grant: writeback pre-empts the read; lowest matching operand of the chosen slot wins.
    always_comb begin
        rd_en_s      = '0;
        wr_en_s      = '0;
        rd_coll_s    = '0;
        rd_op_s      = '0;
        bank_rd_warp = '0;
        bank_rd_reg  = '0;
        gcoll_s      = '0;
        gop_s        = '0;
        found_s      = 1'b0;
        hit_s        = 1'b0;
        for (int c = 0; c < COLLECTOR_NUM; c++) begin
            clear_s[c] = '0;
        end
        for (int b = 0; b < BANK_NUM; b++) begin
            wr_en_s[b] = wb_valid && !rst && (wb_bank_s == BANK_W'(b));
            gcoll_s    = grant_coll_s[b*CID_W +: CID_W];
            gop_s      = '0;
            found_s    = 1'b0;
            for (int o = 0; o < OPERAND_NUM; o++) begin
                hit_s   = !found_s && pending_r[gcoll_s][o] &&
                          (op_bank_s[gcoll_s][o] == BANK_W'(b));
                gop_s   = hit_s ? OID_W'(o) : gop_s;
                found_s = found_s | hit_s;
            end
            if (grant_valid_s[b] && !wr_en_s[b] && !rst) begin
                rd_en_s[b]                       = 1'b1;
                rd_coll_s[b*CID_W +: CID_W]      = gcoll_s;
                rd_op_s[b*OID_W +: OID_W]        = gop_s;
                clear_s[gcoll_s][gop_s]          = 1'b1;
                bank_rd_warp[b*WARP_W +: WARP_W] = warp_r[gcoll_s];
                bank_rd_reg[b*REG_W +: REG_W]    = reg_r[gcoll_s][gop_s];
            end else begin
                rd_en_s[b] = 1'b0;
            end
        end
    end

    // Slot FSM next state: accept when idle, finish when the last operand's read is issued.
    always_comb begin
        accept_s = '0;
        last_s   = '0;
        for (int c = 0; c < COLLECTOR_NUM; c++) begin
            state_nx_s[c] = state_r[c];
            case (state_r[c])
                SLOT_IDLE: begin
                    if (req_valid[c] && req_ready_r[c]) begin
                        accept_s[c]   = 1'b1;
                        state_nx_s[c] = (|req_mask[c*OPERAND_NUM +: OPERAND_NUM]) ? SLOT_BUSY : SLOT_IDLE;
                    end else begin
                        state_nx_s[c] = SLOT_IDLE;
                    end
                end
                SLOT_BUSY: begin
                    last_s[c]     = (|clear_s[c]) && ((pending_r[c] & ~clear_s[c]) == '0);
                    state_nx_s[c] = slot_done_r[c] ? SLOT_IDLE : SLOT_BUSY;
                end
                default: begin
                    state_nx_s[c] = SLOT_IDLE;
                end
            endcase
        end
    end

    // Slot state, latched request fields and pending bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready_r <= '1;
            slot_done_r <= '0;
            for (int c = 0; c < COLLECTOR_NUM; c++) begin
                state_r[c]   <= SLOT_IDLE;
                warp_r[c]    <= '0;
                pending_r[c] <= '0;
                for (int o = 0; o < OPERAND_NUM; o++) begin
                    reg_r[c][o] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < COLLECTOR_NUM; c++) begin
                state_r[c]     <= state_nx_s[c];
                req_ready_r[c] <= (state_nx_s[c] == SLOT_IDLE);
                slot_done_r[c] <= last_s[c] ||
                                  (accept_s[c] && !(|req_mask[c*OPERAND_NUM +: OPERAND_NUM]));
                if (accept_s[c]) begin
                    warp_r[c]    <= req_warp[c*WARP_W +: WARP_W];
                    pending_r[c] <= req_mask[c*OPERAND_NUM +: OPERAND_NUM];
                    for (int o = 0; o < OPERAND_NUM; o++) begin
                        reg_r[c][o] <= req_reg[(c*OPERAND_NUM+o)*REG_W +: REG_W];
                    end
                end else begin
                    pending_r[c] <= pending_r[c] & ~clear_s[c];
                end
            end
        end
    end

    // Round-robin pointers and registered response tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_r <= '0;
            resp_coll_r  <= '0;
            resp_op_r    <= '0;
            for (int b = 0; b < BANK_NUM; b++) begin
                rr_ptr_r[b] <= '0;
            end
        end else begin
            resp_valid_r <= rd_en_s;
            resp_coll_r  <= rd_coll_s;
            resp_op_r    <= rd_op_s;
            for (int b = 0; b < BANK_NUM; b++) begin
                if (rd_en_s[b]) begin
                    rr_ptr_r[b] <= (rd_coll_s[b*CID_W +: CID_W] == CID_W'(COLLECTOR_NUM-1)) ?
                                   CID_W'(0) : rd_coll_s[b*CID_W +: CID_W] + CID_W'(1);
                end else begin
                    rr_ptr_r[b] <= rr_ptr_r[b];
                end
            end
        end
    end

    // Writeback broadcast; only the enabled bank samples it.
    always_comb begin
        if (|wr_en_s) begin
            bank_wr_warp = wb_warp;
            bank_wr_reg  = wb_reg;
            bank_wr_mask = wb_mask;
            bank_wr_data = wb_data;
        end else begin
            bank_wr_warp = '0;
            bank_wr_reg  = '0;
            bank_wr_mask = '0;
            bank_wr_data = '0;
        end
    end

    // Read data pass-through, zero on banks without a response.
    always_comb begin
        resp_data = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            if (resp_valid_r[b]) begin
                resp_data[b*WORD_W +: WORD_W] = bank_rd_data[b*WORD_W +: WORD_W];
            end else begin
                resp_data[b*WORD_W +: WORD_W] = '0;
            end
        end
    end

    assign req_ready      = req_ready_r;
    assign slot_done      = slot_done_r;
    assign bank_rd_en     = rd_en_s;
    assign bank_wr_en     = wr_en_s;
    assign resp_valid     = resp_valid_r;
    assign resp_collector = resp_coll_r;
    assign resp_operand   = resp_op_r;

endmodule

// File: tb/tb_gelato_operand_arbiter.sv
// Directed bench for gelato_operand_arbiter with a simple behavioural bank model.
module tb_gelato_operand_arbiter;

    localparam int B  = 4;
    localparam int C  = 4;
    localparam int O  = 4;
    localparam int WW = 5;
    localparam int RW = 6;
    localparam int T  = 32;
    localparam int DW = T * 32;
    localparam int CW = 2;
    localparam int OW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [C-1:0]      req_valid;
    logic [C-1:0]      req_ready;
    logic [C*WW-1:0]   req_warp;
    logic [C*O*RW-1:0] req_reg;
    logic [C*O-1:0]    req_mask;
    logic              wb_valid;
    logic [WW-1:0]     wb_warp;
    logic [RW-1:0]     wb_reg;
    logic [T-1:0]      wb_mask;
    logic [DW-1:0]     wb_data;
    logic [B-1:0]      bank_rd_en;
    logic [B*WW-1:0]   bank_rd_warp;
    logic [B*RW-1:0]   bank_rd_reg;
    logic [B*DW-1:0]   bank_rd_data;
    logic [B-1:0]      bank_wr_en;
    logic [WW-1:0]     bank_wr_warp;
    logic [RW-1:0]     bank_wr_reg;
    logic [T-1:0]      bank_wr_mask;
    logic [DW-1:0]     bank_wr_data;
    logic [B-1:0]      resp_valid;
    logic [B*CW-1:0]   resp_collector;
    logic [B*OW-1:0]   resp_operand;
    logic [B*DW-1:0]   resp_data;
    logic [C-1:0]      slot_done;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] wdata;
    logic [DW-1:0] mem [0:2047];
    logic [2047:0] written;

    gelato_operand_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_warp(req_warp),
        .req_reg(req_reg), .req_mask(req_mask),
        .wb_valid(wb_valid), .wb_warp(wb_warp), .wb_reg(wb_reg),
        .wb_mask(wb_mask), .wb_data(wb_data),
        .bank_rd_en(bank_rd_en), .bank_rd_warp(bank_rd_warp), .bank_rd_reg(bank_rd_reg),
        .bank_rd_data(bank_rd_data),
        .bank_wr_en(bank_wr_en), .bank_wr_warp(bank_wr_warp), .bank_wr_reg(bank_wr_reg),
        .bank_wr_mask(bank_wr_mask), .bank_wr_data(bank_wr_data),
        .resp_valid(resp_valid), .resp_collector(resp_collector),
        .resp_operand(resp_operand), .resp_data(resp_data),
        .slot_done(slot_done)
    );

    always #5 clk = ~clk;

    // Default register contents, distinct per lane, warp and register.
    function automatic logic [DW-1:0] pat(input int w, input int r);
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < T; i++) v[i*32 +: 32] = {8'(i), 8'(w), 8'(r), 8'h5A};
        return v;
    endfunction

    function automatic logic [DW-1:0] lane_mask(input logic [T-1:0] m);
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < T; i++) v[i*32 +: 32] = {32{m[i]}};
        return v;
    endfunction

    // Bank model: masked writes, one-cycle read latency.
    always @(posedge clk) begin
        if (rst) begin
            written      <= '0;
            bank_rd_data <= '0;
        end else begin
            for (int b = 0; b < B; b++) begin
                if (bank_wr_en[b]) begin
                    mem[{bank_wr_warp, bank_wr_reg}] <=
                        ((written[{bank_wr_warp, bank_wr_reg}] ? mem[{bank_wr_warp, bank_wr_reg}]
                          : pat(int'(bank_wr_warp), int'(bank_wr_reg))) & ~lane_mask(bank_wr_mask)) |
                        (bank_wr_data & lane_mask(bank_wr_mask));
                    written[{bank_wr_warp, bank_wr_reg}] <= 1'b1;
                end
                if (bank_rd_en[b]) begin
                    bank_rd_data[b*DW +: DW] <=
                        written[{bank_rd_warp[b*WW +: WW], bank_rd_reg[b*RW +: RW]}] ?
                        mem[{bank_rd_warp[b*WW +: WW], bank_rd_reg[b*RW +: RW]}] :
                        pat(int'(bank_rd_warp[b*WW +: WW]), int'(bank_rd_reg[b*RW +: RW]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed(low64)=%0h expected(low64)=%0h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    task automatic set_reg(input int c, input int o, input logic [RW-1:0] v);
        req_reg[(c*O+o)*RW +: RW] = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = '0; req_warp = '0; req_reg = '0; req_mask = '0;
        wb_valid = 1'b0; wb_warp = '0; wb_reg = '0; wb_mask = '0; wb_data = '0;
        wdata = {T{32'hCAFE_0004}};
        tick(); tick();
        rst = 1'b0; #1;
        chk("reset_ready", 64'(req_ready), 64'hF);
        chk("reset_rd_en", 64'(bank_rd_en), 64'h0);
        chk("reset_wr_en", 64'(bank_wr_en), 64'h0);
        chk("reset_resp_valid", 64'(resp_valid), 64'h0);
        chk("reset_slot_done", 64'(slot_done), 64'h0);

        // Two slots contend for bank 0: slot 0 first, then slot 1.
        tick();
        req_valid = 4'b0011; req_warp = '0; req_reg = '0;
        set_reg(0, 0, 6'd4); set_reg(1, 0, 6'd4); req_mask = 16'h0011; #1;
        tick(); req_valid = '0; #1;
        chk("rr_rd_en1", 64'(bank_rd_en), 64'h1);
        chk("rr_rd_reg1", 64'(bank_rd_reg[RW-1:0]), 64'd4);
        chk("rr_ready_busy", 64'(req_ready), 64'hC);
        tick(); #1;
        chk("rr_resp1_valid", 64'(resp_valid), 64'h1);
        chk("rr_resp1_coll", 64'(resp_collector[CW-1:0]), 64'd0);
        chk("rr_rd_en2", 64'(bank_rd_en), 64'h1);
        chk("rr_done0", 64'(slot_done), 64'h1);
        tick(); #1;
        chk("rr_resp2_coll", 64'(resp_collector[CW-1:0]), 64'd1);
        chk("rr_done1", 64'(slot_done), 64'h2);
        chk("rr_ptr0", 64'(dut.rr_ptr_r[0]), 64'd2);
        chk("rr_ready_partial", 64'(req_ready), 64'hD);
        tick(); #1;
        chk("rr_ready_all", 64'(req_ready), 64'hF);

        // Slot 0, warp 1, regs 0..3: all four banks in one cycle.
        tick();
        req_valid = 4'b0001; req_warp = '0; req_warp[WW-1:0] = 5'd1; req_reg = '0;
        set_reg(0, 0, 6'd0); set_reg(0, 1, 6'd1); set_reg(0, 2, 6'd2); set_reg(0, 3, 6'd3);
        req_mask = 16'h000F; #1;
        tick(); req_valid = '0; #1;
        chk("quad_rd_en", 64'(bank_rd_en), 64'hF);
        chk("quad_rd_reg", 64'(bank_rd_reg), 64'({6'd2, 6'd1, 6'd0, 6'd3}));
        chk("quad_rd_warp", 64'(bank_rd_warp), 64'({5'd1, 5'd1, 5'd1, 5'd1}));
        tick(); #1;
        chk("quad_resp_valid", 64'(resp_valid), 64'hF);
        chk("quad_resp_op", 64'(resp_operand), 64'h93);
        chk("quad_resp_coll", 64'(resp_collector), 64'h00);
        chk("quad_done", 64'(slot_done), 64'h1);
        chkw("quad_data_b0", resp_data[0 +: DW], pat(1, 3));
        chkw("quad_data_b2", resp_data[2*DW +: DW], pat(1, 1));
        tick(); #1;
        chk("quad_done_clear", 64'(slot_done), 64'h0);
        chk("quad_ready", 64'(req_ready), 64'hF);

        // Slot 2, three operands on bank 0: consecutive grants.
        tick();
        req_valid = 4'b0100; req_warp = '0; req_reg = '0;
        set_reg(2, 0, 6'd0); set_reg(2, 1, 6'd4); set_reg(2, 2, 6'd8);
        req_mask = 16'h0700; #1;
        tick(); req_valid = '0; #1;
        chk("ser_rd_en", 64'(bank_rd_en), 64'h1);
        chk("ser_rd_reg0", 64'(bank_rd_reg[RW-1:0]), 64'd0);
        tick(); #1;
        chk("ser_rd_reg1", 64'(bank_rd_reg[RW-1:0]), 64'd4);
        chk("ser_resp_coll", 64'(resp_collector[CW-1:0]), 64'd2);
        chk("ser_resp_op0", 64'(resp_operand[OW-1:0]), 64'd0);
        chk("ser_no_done0", 64'(slot_done), 64'h0);
        tick(); #1;
        chk("ser_rd_reg2", 64'(bank_rd_reg[RW-1:0]), 64'd8);
        chk("ser_resp_op1", 64'(resp_operand[OW-1:0]), 64'd1);
        chkw("ser_data1", resp_data[0 +: DW], pat(0, 4));
        tick(); #1;
        chk("ser_resp_op2", 64'(resp_operand[OW-1:0]), 64'd2);
        chk("ser_done2", 64'(slot_done), 64'h4);
        chk("ser_rd_idle", 64'(bank_rd_en), 64'h0);

        // Writeback pre-empts a pending read on bank 0; the retried read sees it.
        tick();
        req_valid = 4'b0001; req_warp = '0; req_reg = '0; set_reg(0, 0, 6'd4);
        req_mask = 16'h0001; #1;
        tick();
        req_valid = '0;
        wb_valid = 1'b1; wb_warp = 5'd0; wb_reg = 6'd4; wb_mask = '1; wb_data = wdata; #1;
        chk("wb_wr_en", 64'(bank_wr_en), 64'h1);
        chk("wb_rd_blocked", 64'(bank_rd_en), 64'h0);
        chkw("wb_wr_data", bank_wr_data, wdata);
        tick(); wb_valid = 1'b0; #1;
        chk("wb_wr_off", 64'(bank_wr_en), 64'h0);
        chk("wb_rd_retry", 64'(bank_rd_en), 64'h1);
        tick(); #1;
        chk("wb_resp_valid", 64'(resp_valid), 64'h1);
        chkw("wb_resp_data", resp_data[0 +: DW], wdata);
        chk("wb_done", 64'(slot_done), 64'h1);

        // Zero-mask request: immediate done, no bank activity, stays ready.
        tick();
        req_valid = 4'b1000; req_reg = '0; req_mask = '0; #1;
        tick(); req_valid = '0; #1;
        chk("zero_done", 64'(slot_done), 64'h8);
        chk("zero_ready", 64'(req_ready), 64'hF);
        chk("zero_rd_en", 64'(bank_rd_en), 64'h0);
        tick(); #1;
        chk("zero_done_clear", 64'(slot_done), 64'h0);
        chk("zero_resp_idle", 64'(resp_valid), 64'h0);

        // Reset while slot 1 holds two pending operands.
        tick();
        req_valid = 4'b0010; req_reg = '0; set_reg(1, 0, 6'd4); set_reg(1, 1, 6'd8);
        req_mask = 16'h0030; #1;
        tick(); req_valid = '0; rst = 1'b1; #1;
        chk("rst_rd_gated", 64'(bank_rd_en), 64'h0);
        tick(); rst = 1'b0; #1;
        chk("rst_ready", 64'(req_ready), 64'hF);
        chk("rst_rd_en", 64'(bank_rd_en), 64'h0);
        chk("rst_resp_valid", 64'(resp_valid), 64'h0);
        chk("rst_slot_done", 64'(slot_done), 64'h0);
        tick(); #1;
        chk("rst_no_stale_resp", 64'(resp_valid), 64'h0);
        chk("rst_no_stale_rd", 64'(bank_rd_en), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
